arb_client_ctrl: RTL and testbench

Requester-side controller that sits between N job sources and the programmable priority arbiter. It keeps a pending-job count per channel and drives the arbiter's `req` vector. It consumes the registered one-hot `grant`, runs a fixed-length transfer burst for the granted channel, and then releases the request so the arbiter can re-arbitrate.

---
 rtl/arb_client_if.sv | 25 ++
 rtl/arb_client_ctrl.sv | 82 ++++++++
 tb/tb_arb_client_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_client_if.sv
// arb_client_if: job/request/grant/burst bundle between job sources, the arbiter and arb_client_ctrl (master = controller side)
interface arb_client_if #(
  parameter int N = 4,
  parameter int BURST_W = 4
);
  logic en;
  logic [N-1:0] job_valid;
  logic [N-1:0] job_ready;
  logic [BURST_W-1:0] burst_len;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic xfer_valid;
  logic [$clog2(N)-1:0] xfer_ch;
  logic xfer_last;
  logic [N-1:0] done;
  logic err;
  modport master (
    input en, job_valid, burst_len, grant,
    output job_ready, req, xfer_valid, xfer_ch, xfer_last, done, err
  );
  modport slave (
    output en, job_valid, burst_len, grant,
    input job_ready, req, xfer_valid, xfer_ch, xfer_last, done, err
  );
endinterface

// File: rtl/arb_client_ctrl.sv
// arb_client_ctrl: per-channel pending-job counters driving arbiter req, one fixed burst per accepted grant; ports clk, rst, bus (arb_client_if.master); define ARB_CLIENT_TIMEOUT_EN for a TIMEOUT-cycle grant-wait limit
module arb_client_ctrl #(
  parameter int N = 4,
  parameter int CNT_W = 4,
  parameter int BURST_W = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  arb_client_if.master bus
);
  localparam int CH_W = $clog2(N);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, XFER, RELEASE} state_t;
  state_t state;
  logic [CNT_W-1:0] pending [N];
  logic [BURST_W-1:0] beat;
  logic [CH_W-1:0] ch, gnt_idx;
  logic [N-1:0] nz, ready, ch_oh, acc, last_oh;
  logic valid_gnt, bad_gnt, beat_fire, last_fire, tmo;
  always_comb begin
    nz = '0;
    ready = '0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      nz[i] = pending[i] != '0;
      ready[i] = pending[i] != {CNT_W{1'b1}};
      if (bus.grant[i]) gnt_idx = CH_W'(i);
    end
  end
  assign ch_oh = N'(1) << ch;
  assign valid_gnt = state == WAIT_GNT && bus.en && $onehot(bus.grant) && |(bus.grant & nz);
  assign bad_gnt = state == WAIT_GNT && bus.en && |bus.grant && !valid_gnt;
  assign beat_fire = state == XFER && bus.en && bus.grant[ch];
  assign last_fire = beat_fire && beat == '0;
  assign acc = bus.job_valid & ready;
  assign last_oh = last_fire ? ch_oh : '0;
`ifdef ARB_CLIENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  assign tmo = state == WAIT_GNT && bus.en && !valid_gnt && wait_cnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst || state != WAIT_GNT) wait_cnt <= '0;
    else if (bus.en) wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      ch <= '0;
      for (int i = 0; i < N; i++) pending[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) pending[i] <= pending[i] + CNT_W'(acc[i]) - CNT_W'(last_oh[i]);
      case (state)
        IDLE: if (bus.en && |nz) state <= WAIT_GNT;
        WAIT_GNT: begin
          if (valid_gnt) begin
            state <= XFER;
            ch <= gnt_idx;
            beat <= bus.burst_len;
          end else if (tmo) state <= IDLE;
        end
        XFER: begin
          if (last_fire) state <= RELEASE;
          else if (beat_fire) beat <= beat - 1'b1;
        end
        RELEASE: if (bus.en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // req is built only from registered state and counters; grant never reaches it combinationally
  assign bus.req = state == WAIT_GNT ? nz : state == XFER ? ch_oh : '0;
  assign bus.job_ready = ready;
  assign bus.xfer_valid = beat_fire;
  assign bus.xfer_ch = ch;
  assign bus.xfer_last = last_fire;
  assign bus.done = state == RELEASE && bus.en ? ch_oh : '0;
  assign bus.err = bad_gnt || tmo;
endmodule

// File: tb/tb_arb_client_ctrl.sv
// tb_arb_client_ctrl: directed and randomized checks of arb_client_ctrl against a job/burst scoreboard and a registered priority arbiter model
module tb_arb_client_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  arb_client_if #(.N(4), .BURST_W(4)) bus ();
  arb_client_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0, checks = 0;
  int n, beats, lasts;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  int prio_hi;
  logic force_en;
  logic [3:0] force_val, arb_gnt;
  function automatic logic [3:0] pick(input logic [3:0] r);
    logic [3:0] g = '0;
    for (int k = 0; k < 4; k++) begin
      if (r[(prio_hi + 4 - k) % 4] && g == '0) g[(prio_hi + 4 - k) % 4] = 1'b1;
    end
    return g;
  endfunction
  always @(posedge clk) arb_gnt <= rst ? 4'b0 : pick(bus.req);
  assign bus.grant = force_en ? force_val : arb_gnt;
  int pend [4];
  int bch, bcnt;
  logic in_burst, done_due, mon_on, last_now;
  logic [3:0] m_rdy, m_nz, m_acc, m_dec;
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pend[i] = 0;
      in_burst = 1'b0;
      done_due = 1'b0;
      bch = 0;
    end else if (mon_on) begin
      for (int i = 0; i < 4; i++) begin
        m_rdy[i] = pend[i] != 15;
        m_nz[i] = pend[i] != 0;
      end
      check("job_ready", bus.job_ready, m_rdy);
      check("done", bus.done, done_due ? 4'b0001 << bch : 4'b0);
      check("req_subset", bus.req & ~m_nz, 0);
      last_now = 1'b0;
      m_dec = '0;
      if (bus.xfer_valid) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          bch = int'(bus.xfer_ch);
          bcnt = 0;
          check("burst_pend", m_nz[bch], 1);
        end
        check("xfer_ch", bus.xfer_ch, bch);
        bcnt++;
        last_now = bcnt == int'(bus.burst_len) + 1;
        check("xfer_last", bus.xfer_last, last_now);
      end else check("last_idle", bus.xfer_last, 0);
      done_due = last_now;
      if (last_now) begin
        in_burst = 1'b0;
        m_dec[bch] = 1'b1;
      end
      m_acc = bus.job_valid & m_rdy;
      for (int i = 0; i < 4; i++) pend[i] += int'(m_acc[i]) - int'(m_dec[i]);
    end
  end
  function automatic int pend_sum();
    return pend[0] + pend[1] + pend[2] + pend[3] + int'(in_burst) + int'(done_due);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic sig(input int sel);
    return sel == 0 ? bus.xfer_valid : sel == 1 ? |bus.done : sel == 2 ? |bus.req : bus.err;
  endfunction
  task automatic wait_on(input string tag, input int sel, input int lim);
    int c = 0;
    @(negedge clk);
    while (!sig(sel) && c < lim) begin
      tick();
      @(negedge clk);
      c++;
    end
    check({tag, "_seen"}, sig(sel), 1);
  endtask
  task automatic reset_outputs(input string tag);
    check({tag, "_req"}, bus.req, 0);
    check({tag, "_ready"}, bus.job_ready, 4'hf);
    check({tag, "_valid"}, bus.xfer_valid, 0);
    check({tag, "_ch"}, bus.xfer_ch, 0);
    check({tag, "_last"}, bus.xfer_last, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.en = 1'b1;
    bus.job_valid = '0;
    bus.burst_len = '0;
    force_en = 1'b0;
    force_val = '0;
    prio_hi = 2;
    mon_on = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_outputs("rst");
    mon_on = 1'b1;
    bus.burst_len = 4'd3;
    tick(); bus.job_valid = 4'b0100;
    tick(); bus.job_valid = '0;
    @(negedge clk); check("t2_req_t1", bus.req, 0);
    tick(); @(negedge clk); check("t2_req_t2", bus.req, 4'b0100);
    tick(); @(negedge clk); check("t2_no_beat_t3", bus.xfer_valid, 0);
    for (int b = 0; b < 4; b++) begin
      tick(); @(negedge clk);
      check("t2_beat", bus.xfer_valid, 1);
      check("t2_ch", bus.xfer_ch, 2);
      check("t2_last", bus.xfer_last, b == 3);
    end
    tick(); @(negedge clk);
    check("t2_done", bus.done, 4'b0100);
    check("t2_req_release", bus.req, 0);
    repeat (3) tick();
    @(negedge clk);
    check("t2_req_after", bus.req, 0);
    check("t2_ready_after", bus.job_ready, 4'hf);
    bus.burst_len = 4'($urandom_range(0, 3));
    prio_hi = 3;
    tick(); bus.job_valid = 4'b1001;
    tick(); bus.job_valid = '0;
    wait_on("t3_first", 0, 20);
    check("t3_first_ch", bus.xfer_ch, 3);
    tick(); wait_on("t3_done_a", 1, 30);
    check("t3_done_a", bus.done, 4'b1000);
    check("t3_release_req", bus.req, 0);
    tick(); wait_on("t3_req_b", 2, 5);
    check("t3_req_b", bus.req, 4'b0001);
    tick(); wait_on("t3_second", 0, 10);
    check("t3_second_ch", bus.xfer_ch, 0);
    tick(); wait_on("t3_done_b", 1, 30);
    check("t3_done_b", bus.done, 4'b0001);
    bus.burst_len = 4'd2;
    tick(); bus.job_valid = 4'b0010;
    tick(); bus.job_valid = '0;
    wait_on("t4_start", 0, 20);
    beats = 1;
    lasts = int'(bus.xfer_last);
    for (int k = 0; k < 7; k++) begin
      tick();
      force_en = k < 2;
      force_val = '0;
      @(negedge clk);
      if (k < 2) check("t4_stall", bus.xfer_valid, 0);
      beats += int'(bus.xfer_valid);
      lasts += int'(bus.xfer_valid & bus.xfer_last);
    end
    check("t4_beats", beats, 3);
    check("t4_lasts", lasts, 1);
    prio_hi = 0;
    tick(); force_en = 1'b1; force_val = '0; bus.job_valid = 4'b0011;
    tick(); bus.job_valid = '0;
    repeat (3) tick();
    @(negedge clk); check("t5_req", bus.req, 4'b0011);
    tick(); force_val = 4'b0110;
    @(negedge clk); check("t5_err_multi", bus.err, 1); check("t5_no_beat", bus.xfer_valid, 0);
    tick(); force_val = 4'b1000;
    @(negedge clk); check("t5_err_unreq", bus.err, 1); check("t5_no_beat2", bus.xfer_valid, 0);
    tick(); force_val = '0;
    @(negedge clk); check("t5_err_clear", bus.err, 0); check("t5_still_wait", bus.req, 4'b0011);
    tick(); force_en = 1'b0;
    wait_on("t5_done_a", 1, 30);
    tick(); wait_on("t5_done_b", 1, 30);
    bus.burst_len = '0;
    tick(); force_en = 1'b1; force_val = '0;
    for (int k = 0; k < 16; k++) begin
      bus.job_valid = 4'b0010;
      @(negedge clk);
      check("t6_ready", bus.job_ready[1], k < 15);
      tick();
    end
    bus.job_valid = '0;
    @(negedge clk); check("t6_full_ready", bus.job_ready[1], 0); check("t6_req", bus.req, 4'b0010);
    tick(); force_val = 4'b0010;
    tick(); @(negedge clk); check("t6_beat_a", bus.xfer_last, 1);
    tick(); force_val = '0;
    @(negedge clk); check("t6_ready_14", bus.job_ready[1], 1);
    tick(); tick();
    @(negedge clk); check("t6_rewait", bus.req, 4'b0010);
    tick(); force_val = 4'b0010;
    tick(); bus.job_valid = 4'b0010;
    @(negedge clk); check("t6_beat_b", bus.xfer_last, 1); check("t6_ready_same", bus.job_ready[1], 1);
    tick(); bus.job_valid = '0; force_val = '0;
    @(negedge clk); check("t6_done_b", bus.done, 4'b0010); check("t6_count_kept", bus.job_ready[1], 1);
    tick(); bus.job_valid = 4'b0010;
    tick(); bus.job_valid = '0;
    @(negedge clk); check("t6_full_again", bus.job_ready[1], 0);
    tick(); bus.burst_len = 4'd5; force_val = 4'b0010;
    tick(); @(negedge clk); check("t7_beat", bus.xfer_valid, 1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; force_en = 1'b0;
    @(negedge clk); reset_outputs("t7");
    for (int k = 0; k < 3; k++) begin
      tick(); @(negedge clk);
      check("t7_no_done", bus.done, 0);
      check("t7_no_req", bus.req, 0);
    end
    tick(); bus.en = 1'b0; bus.job_valid = 4'b0001;
    tick(); bus.job_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick(); @(negedge clk);
      check("t8_en_hold", bus.req, 0);
    end
    tick(); bus.en = 1'b1;
    wait_on("t8_req", 2, 4);
    check("t8_req_val", bus.req, 4'b0001);
    tick(); wait_on("t8_done", 1, 30);
`ifdef ARB_CLIENT_TIMEOUT_EN
    tick(); force_en = 1'b1; force_val = '0; bus.job_valid = 4'b0100;
    tick(); bus.job_valid = '0;
    wait_on("t9_req", 2, 5);
    n = 1;
    while (!bus.err && n < 200) begin
      tick(); @(negedge clk);
      n++;
    end
    check("t9_timeout_cycle", n, 64);
    tick(); @(negedge clk); check("t9_idle", bus.req, 0);
    tick(); @(negedge clk); check("t9_rereq", bus.req, 4'b0100);
    tick(); force_en = 1'b0;
    wait_on("t9_done", 1, 30);
`endif
    for (int p = 0; p < 2; p++) begin
      tick();
      bus.burst_len = 4'($urandom_range(0, 3));
      for (int c = 0; c < 600; c++) begin
        for (int i = 0; i < 4; i++) bus.job_valid[i] = $urandom_range(0, 7) == 0;
        force_en = $urandom_range(0, 9) == 0;
        force_val = '0;
        prio_hi = $urandom_range(0, 3);
        tick();
      end
      bus.job_valid = '0;
      force_en = 1'b0;
      n = 0;
      @(negedge clk);
      while (pend_sum() != 0 && n < 3000) begin
        tick(); @(negedge clk);
        n++;
      end
      check("rand_drained", pend_sum(), 0);
      repeat (3) tick();
      @(negedge clk);
      check("rand_idle_req", bus.req, 0);
      check("rand_idle_ready", bus.job_ready, 4'hf);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
